// File: rtl/fixed_addsub_pipe.sv
// Fixed-point add/subtract joining two operand streams into one result stream, with saturation and an overflow counter.
// Latency: LATENCY cycles from accept to S_vld when not stalled; one beat per cycle sustained.
// Backpressure: S_rdy ripples combinationally to A_rdy/B_rdy, and bubbles collapse. Holds LATENCY beats when stalled.
module fixed_addsub_pipe #(
    parameter int WIDTH    = 16,
    parameter int LATENCY  = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A_vld,
    input  logic [WIDTH-1:0] A_dat,
    input  logic             A_op,
    output logic             A_rdy,
    input  logic             B_vld,
    input  logic [WIDTH-1:0] B_dat,
    output logic             B_rdy,
    output logic             S_vld,
    output logic [WIDTH-1:0] S_dat,
    output logic             S_ovf,
    input  logic             S_rdy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] clamp;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             acc;
    logic             any_free;

    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] load;
    logic [LATENCY-1:0] v_src;
    logic [LATENCY-1:0] o;
    logic [LATENCY-1:0] o_src;
    logic [WIDTH-1:0]   d     [LATENCY];
    logic [WIDTH-1:0]   d_src [LATENCY];

    // One extra bit holds the exact sum/difference, so its top bits expose overflow.
    always_comb begin
        ext_a = {(SIGNED != 0) ? A_dat[WIDTH-1] : 1'b0, A_dat};
        ext_b = {(SIGNED != 0) ? B_dat[WIDTH-1] : 1'b0, B_dat};
        sum   = A_op ? (ext_a - ext_b) : (ext_a + ext_b);
        ovf   = 1'b0;
        clamp = '0;
        if (SIGNED != 0) begin
            ovf   = sum[WIDTH] ^ sum[WIDTH-1];
            clamp = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            ovf   = sum[WIDTH];
            clamp = A_op ? '0 : '1;
        end
        res = sum[WIDTH-1:0];
        if ((SATURATE != 0) && ovf) begin
            res = clamp;
        end
    end

    // Stage i can load when the output drains or any stage from i onward is empty.
    always_comb begin
        any_free = 1'b0;
        load     = '0;
        for (int i = 0; i < LATENCY; i++) begin
            any_free = S_rdy;
            for (int j = i; j < LATENCY; j++) begin
                any_free = any_free | ~v[j];
            end
            load[i] = any_free;
        end
    end

    assign A_rdy = rst_n & load[0];
    assign B_rdy = A_rdy;
    assign acc   = A_vld & B_vld & A_rdy;

    always_comb begin
        v_src    = '0;
        o_src    = '0;
        v_src[0] = acc;
        o_src[0] = ovf;
        d_src[0] = res;
        for (int i = 1; i < LATENCY; i++) begin
            v_src[i] = v[i-1];
            o_src[i] = o[i-1];
            d_src[i] = d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            o <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (load[i]) begin
                    v[i] <= v_src[i];
                    o[i] <= o_src[i];
                    d[i] <= d_src[i];
                end
            end
        end
    end

    assign S_vld = v[LATENCY-1];
    assign S_dat = d[LATENCY-1];
    assign S_ovf = o[LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (S_vld && S_rdy && S_ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Bench for fixed_addsub_pipe: four LATENCY=2 variants share one stream, a LATENCY=3 instance covers stalls.
module tb_fixed_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m_a_vld, m_a_op, m_b_vld, m_s_rdy, m_clr;
    logic [15:0] m_a_dat, m_b_dat;
    logic        l3_a_vld, l3_a_op, l3_b_vld, l3_s_rdy, l3_clr;
    logic [15:0] l3_a_dat, l3_b_dat;

    logic        s2_a_rdy, s2_b_rdy, s2_vld, s2_ovf;
    logic [15:0] s2_dat, s2_cnt;
    logic        us_a_rdy, us_b_rdy, us_vld, us_ovf;
    logic [15:0] us_dat, us_cnt;
    logic        uw_a_rdy, uw_b_rdy, uw_vld, uw_ovf;
    logic [15:0] uw_dat, uw_cnt;
    logic        c4_a_rdy, c4_b_rdy, c4_vld, c4_ovf;
    logic [15:0] c4_dat;
    logic [3:0]  c4_cnt;
    logic        l3_a_rdy, l3_b_rdy, l3_vld, l3_ovf;
    logic [15:0] l3_dat, l3_cnt;

    fixed_addsub_pipe #(.WIDTH(16), .LATENCY(2), .SIGNED(1), .SATURATE(1), .CNT_W(16)) u_s2 (
        .clk(clk), .rst_n(rst_n), .A_vld(m_a_vld), .A_dat(m_a_dat), .A_op(m_a_op), .A_rdy(s2_a_rdy),
        .B_vld(m_b_vld), .B_dat(m_b_dat), .B_rdy(s2_b_rdy), .S_vld(s2_vld), .S_dat(s2_dat),
        .S_ovf(s2_ovf), .S_rdy(m_s_rdy), .cnt_clr(m_clr), .ovf_cnt(s2_cnt));
    fixed_addsub_pipe #(.WIDTH(16), .LATENCY(2), .SIGNED(0), .SATURATE(1), .CNT_W(16)) u_us (
        .clk(clk), .rst_n(rst_n), .A_vld(m_a_vld), .A_dat(m_a_dat), .A_op(m_a_op), .A_rdy(us_a_rdy),
        .B_vld(m_b_vld), .B_dat(m_b_dat), .B_rdy(us_b_rdy), .S_vld(us_vld), .S_dat(us_dat),
        .S_ovf(us_ovf), .S_rdy(m_s_rdy), .cnt_clr(m_clr), .ovf_cnt(us_cnt));
    fixed_addsub_pipe #(.WIDTH(16), .LATENCY(2), .SIGNED(0), .SATURATE(0), .CNT_W(16)) u_uw (
        .clk(clk), .rst_n(rst_n), .A_vld(m_a_vld), .A_dat(m_a_dat), .A_op(m_a_op), .A_rdy(uw_a_rdy),
        .B_vld(m_b_vld), .B_dat(m_b_dat), .B_rdy(uw_b_rdy), .S_vld(uw_vld), .S_dat(uw_dat),
        .S_ovf(uw_ovf), .S_rdy(m_s_rdy), .cnt_clr(m_clr), .ovf_cnt(uw_cnt));
    fixed_addsub_pipe #(.WIDTH(16), .LATENCY(2), .SIGNED(1), .SATURATE(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .A_vld(m_a_vld), .A_dat(m_a_dat), .A_op(m_a_op), .A_rdy(c4_a_rdy),
        .B_vld(m_b_vld), .B_dat(m_b_dat), .B_rdy(c4_b_rdy), .S_vld(c4_vld), .S_dat(c4_dat),
        .S_ovf(c4_ovf), .S_rdy(m_s_rdy), .cnt_clr(m_clr), .ovf_cnt(c4_cnt));
    fixed_addsub_pipe #(.WIDTH(16), .LATENCY(3), .SIGNED(1), .SATURATE(1), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .A_vld(l3_a_vld), .A_dat(l3_a_dat), .A_op(l3_a_op), .A_rdy(l3_a_rdy),
        .B_vld(l3_b_vld), .B_dat(l3_b_dat), .B_rdy(l3_b_rdy), .S_vld(l3_vld), .S_dat(l3_dat),
        .S_ovf(l3_ovf), .S_rdy(l3_s_rdy), .cnt_clr(l3_clr), .ovf_cnt(l3_cnt));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] a, input logic op, input logic [15:0] b);
        @(negedge clk);
        m_a_vld = 1'b1; m_b_vld = 1'b1;
        m_a_dat = a; m_a_op = op; m_b_dat = b;
    endtask

    task automatic idle_main();
        @(negedge clk);
        m_a_vld = 1'b0; m_b_vld = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a;  logic op; logic [15:0] b;
        logic [15:0] ss; logic os;
        logic [15:0] us; logic [15:0] uw; logic ou;
    } vec_t;
    vec_t vt [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt_s, cnt_u, cnt_c4, sent, got, nres;
        bit seen_full, stall_have;
        logic [15:0] held;

        // {a, op, b, signed-sat result, signed ovf, unsigned-sat, unsigned-wrap, unsigned ovf}
        vt[0]  = '{16'h7FFF, 1'b0, 16'h0001, 16'h7FFF, 1'b1, 16'h8000, 16'h8000, 1'b0};
        vt[1]  = '{16'h8000, 1'b1, 16'h0001, 16'h8000, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0};
        vt[2]  = '{16'h0005, 1'b1, 16'h0007, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE, 1'b1};
        vt[3]  = '{16'h0003, 1'b1, 16'h0005, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE, 1'b1};
        vt[4]  = '{16'hFFFF, 1'b0, 16'h0002, 16'h0001, 1'b0, 16'hFFFF, 16'h0001, 1'b1};
        vt[5]  = '{16'h1234, 1'b0, 16'h4321, 16'h5555, 1'b0, 16'h5555, 16'h5555, 1'b0};
        vt[6]  = '{16'h8000, 1'b0, 16'h8000, 16'h8000, 1'b1, 16'hFFFF, 16'h0000, 1'b1};
        vt[7]  = '{16'h7FFF, 1'b1, 16'hFFFF, 16'h7FFF, 1'b1, 16'h0000, 16'h8000, 1'b1};
        vt[8]  = '{16'h0000, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 16'h8000, 1'b1};
        vt[9]  = '{16'hC000, 1'b0, 16'hC000, 16'h8000, 1'b0, 16'hFFFF, 16'h8000, 1'b1};
        vt[10] = '{16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};

        rst_n = 1'b0;
        m_a_vld = 0; m_b_vld = 0; m_a_op = 0; m_a_dat = 0; m_b_dat = 0; m_s_rdy = 1; m_clr = 0;
        l3_a_vld = 0; l3_b_vld = 0; l3_a_op = 0; l3_a_dat = 0; l3_b_dat = 0; l3_s_rdy = 1; l3_clr = 0;
        cnt_s = 0; cnt_u = 0; cnt_c4 = 0;

        @(negedge clk); #1;
        chk("rst_rdy_vld", {s2_a_rdy, s2_b_rdy, s2_vld, us_a_rdy, uw_a_rdy, c4_a_rdy, l3_a_rdy, l3_b_rdy, l3_vld}, 0);
        chk("rst_s2_dat", s2_dat, 0);
        chk("rst_s2_ovf", s2_ovf, 0);
        chk("rst_s2_cnt", s2_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LATENCY=3 stream of 10 beats with the consumer stalled for cycles 2..8.
        sent = 0; got = 0; seen_full = 0; stall_have = 0; held = '0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            l3_s_rdy = !(c >= 2 && c <= 8);
            l3_a_vld = (sent < 10); l3_b_vld = (sent < 10);
            l3_a_dat = 16'(100 + sent); l3_b_dat = 16'(sent); l3_a_op = 1'b0;
            #1;
            if (!l3_a_rdy && !seen_full && sent < 10) begin
                seen_full = 1;
                chk("l3_full_after", sent, 3);
            end
            if (l3_vld && !l3_s_rdy) begin
                if (stall_have) chk("l3_stall_hold", l3_dat, held);
                held = l3_dat; stall_have = 1;
            end else begin
                stall_have = 0;
            end
            if (got > 0 && l3_s_rdy) chk("l3_no_gap", l3_vld, 1);
            if (l3_vld && l3_s_rdy) begin
                chk($sformatf("l3_order%0d", got), l3_dat, 16'(100 + 2 * got));
                chk("l3_ovf", l3_ovf, 0);
                got++;
            end
            if (l3_a_vld && l3_b_vld && l3_a_rdy) sent++;
        end
        chk("l3_all_done", got, 10);
        chk("l3_seen_full", seen_full, 1);
        l3_a_vld = 0; l3_b_vld = 0; l3_s_rdy = 1;

        // Table: one beat per vector through all four LATENCY=2 variants.
        for (int i = 0; i < 11; i++) begin
            send_beat(vt[i].a, vt[i].op, vt[i].b);
            #1;
            chk($sformatf("v%0d_rdy", i), {s2_a_rdy, s2_b_rdy, us_a_rdy, us_b_rdy, uw_a_rdy, uw_b_rdy, c4_a_rdy, c4_b_rdy}, 8'hFF);
            idle_main(); #1;
            chk($sformatf("v%0d_early", i), {s2_vld, us_vld, uw_vld, c4_vld}, 0);
            @(negedge clk); #1;
            chk($sformatf("v%0d_vld", i), {s2_vld, us_vld, uw_vld, c4_vld}, 4'hF);
            chk($sformatf("v%0d_s2_dat", i), s2_dat, vt[i].ss);
            chk($sformatf("v%0d_s2_ovf", i), s2_ovf, vt[i].os);
            chk($sformatf("v%0d_c4_dat", i), {c4_dat, 3'b0, c4_ovf}, {vt[i].ss, 3'b0, vt[i].os});
            chk($sformatf("v%0d_us_dat", i), us_dat, vt[i].us);
            chk($sformatf("v%0d_us_ovf", i), us_ovf, vt[i].ou);
            chk($sformatf("v%0d_uw_dat", i), uw_dat, vt[i].uw);
            chk($sformatf("v%0d_uw_ovf", i), uw_ovf, vt[i].ou);
            if (vt[i].os) begin
                cnt_s++;
                cnt_c4 = (cnt_c4 == 15) ? 15 : cnt_c4 + 1;
            end
            if (vt[i].ou) cnt_u++;
            @(negedge clk); #1;
            chk($sformatf("v%0d_gone", i), s2_vld, 0);
            chk($sformatf("v%0d_s2_cnt", i), s2_cnt, cnt_s);
            chk($sformatf("v%0d_c4_cnt", i), c4_cnt, cnt_c4);
            chk($sformatf("v%0d_u_cnt", i), {us_cnt, uw_cnt}, {16'(cnt_u), 16'(cnt_u)});
        end

        // Lone A for 4 cycles, then B joins: exactly one beat.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_a_vld = 1; m_b_vld = 0; m_a_dat = 16'h0010; m_a_op = 0; m_b_dat = 16'h0020;
            #1;
            chk("lone_a_no_out", s2_vld, 0);
        end
        @(negedge clk); m_b_vld = 1; #1;
        chk("join_rdy", s2_a_rdy, 1);
        idle_main(); #1;
        chk("join_early", s2_vld, 0);
        @(negedge clk); #1;
        chk("join_vld", s2_vld, 1);
        chk("join_dat", s2_dat, 16'h0030);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("join_single", s2_vld, 0);
        end

        // Reset with two beats in flight.
        send_beat(16'h7FFF, 1'b0, 16'h0001);
        send_beat(16'h0001, 1'b0, 16'h0001);
        idle_main(); #2;
        rst_n = 1'b0; #1;
        chk("rst_mid_vld", {s2_vld, s2_a_rdy, s2_b_rdy}, 0);
        chk("rst_mid_dat", {s2_dat, 3'b0, s2_ovf}, 0);
        chk("rst_mid_cnt", s2_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt_s = 0; cnt_c4 = 0;
        send_beat(16'h0001, 1'b0, 16'h0002);
        idle_main();
        nres = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (s2_vld) begin
                nres++;
                chk("post_rst_dat", s2_dat, 16'h0003);
                chk("post_rst_when", k, 1);
            end
            @(negedge clk);
        end
        chk("post_rst_count", nres, 1);

        // Counter saturation on the 4-bit counter.
        for (int k = 0; k < 15; k++) send_beat(16'h7FFF, 1'b0, 16'h0001);
        idle_main();
        repeat (3) @(negedge clk);
        #1;
        chk("c4_at_max", c4_cnt, 4'hF);
        chk("s2_cnt_15", s2_cnt, 15);
        send_beat(16'h7FFF, 1'b0, 16'h0001);
        idle_main();
        repeat (3) @(negedge clk);
        #1;
        chk("c4_hold_max", c4_cnt, 4'hF);
        chk("s2_cnt_16", s2_cnt, 16);

        // Clear coinciding with a counted overflow.
        send_beat(16'h8000, 1'b1, 16'h0001);
        idle_main();
        @(negedge clk); m_clr = 1; #1;
        chk("clr_pre_vld_ovf", {s2_vld, s2_ovf}, 2'b11);
        @(negedge clk); m_clr = 0; #1;
        chk("clr_s2_cnt", s2_cnt, 0);
        chk("clr_c4_cnt", c4_cnt, 0);
        chk("l3_cnt_zero", l3_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
